// File: rtl/llc_rst_flush_sweep.sv
// Sweep sequencer for the LLC local memory. It walks every set to either reset it
// (invalidate all ways, clear the evict pointer) or flush it (drop clean lines, report dirty ones).
module llc_rst_flush_sweep #(
  parameter int SET_BITS   = 9,
  parameter int NUM_WAYS   = 16,
  parameter int STATE_BITS = 3,
  parameter int WAY_BITS   = 4,
  parameter logic [STATE_BITS-1:0] INVALID = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_rst,
  input  logic                           start_flush,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_rd_en,
  output logic [SET_BITS-1:0]            mem_set,
  output logic [NUM_WAYS-1:0]            mem_wr_rst_flush,
  output logic [STATE_BITS-1:0]          mem_wr_data_state,
  output logic                           mem_wr_data_dirty_bit,
  output logic                           mem_wr_en_evict_way,
  output logic [WAY_BITS-1:0]            mem_wr_data_evict_way,
  input  logic [NUM_WAYS*STATE_BITS-1:0] rd_data_state,
  input  logic [NUM_WAYS-1:0]            rd_data_dirty_bit,
  output logic                           dirty_valid,
  output logic [NUM_WAYS-1:0]            dirty_ways,
  input  logic                           dirty_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_WR,
    S_FL_RD,
    S_FL_EVAL,
    S_FL_REPORT,
    S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [SET_BITS-1:0]   cnt_reg, cnt_next;
  logic [NUM_WAYS-1:0]   dirty_ways_reg, dirty_ways_next;
  logic [NUM_WAYS-1:0]   way_valid, clean_mask, dirty_mask;
  logic                  cnt_last;

  assign cnt_last = &cnt_reg;

  // Per-way classification of the set read in FL_RD; only meaningful in FL_EVAL.
  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      assign way_valid[gi]  = rd_data_state[gi*STATE_BITS +: STATE_BITS] != INVALID;
      assign clean_mask[gi] = way_valid[gi] & ~rd_data_dirty_bit[gi];
      assign dirty_mask[gi] = way_valid[gi] &  rd_data_dirty_bit[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      dirty_ways_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      dirty_ways_reg <= dirty_ways_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    dirty_ways_next = dirty_ways_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_rst) begin
          state_next = S_RST_WR;
          cnt_next   = '0;
        end else if (start_flush) begin
          state_next = S_FL_RD;
          cnt_next   = '0;
        end
      end
      S_RST_WR: begin
        if (cnt_last) state_next = S_DONE;
        else          cnt_next   = cnt_reg + SET_BITS'(1);
      end
      S_FL_RD: begin
        state_next = S_FL_EVAL;
      end
      S_FL_EVAL: begin
        dirty_ways_next = dirty_mask;
        if (|dirty_mask) begin
          state_next = S_FL_REPORT;
        end else if (cnt_last) begin
          state_next = S_DONE;
        end else begin
          state_next = S_FL_RD;
          cnt_next   = cnt_reg + SET_BITS'(1);
        end
      end
      S_FL_REPORT: begin
        // Dirty ways stay valid here; the controller owns their writeback.
        if (dirty_ready) begin
          if (cnt_last) begin
            state_next = S_DONE;
          end else begin
            state_next = S_FL_RD;
            cnt_next   = cnt_reg + SET_BITS'(1);
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy                = 1'b0;
    done                = 1'b0;
    mem_rd_en           = 1'b0;
    mem_set             = '0;
    mem_wr_rst_flush    = '0;
    mem_wr_en_evict_way = 1'b0;
    dirty_valid         = 1'b0;
    dirty_ways          = '0;
    case (state_reg)
      S_RST_WR: begin
        busy                = 1'b1;
        mem_set             = cnt_reg;
        mem_wr_rst_flush    = '1;
        mem_wr_en_evict_way = 1'b1;
      end
      S_FL_RD: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_set   = cnt_reg;
      end
      S_FL_EVAL: begin
        busy             = 1'b1;
        mem_set          = cnt_reg;
        mem_wr_rst_flush = clean_mask;
      end
      S_FL_REPORT: begin
        busy        = 1'b1;
        mem_set     = cnt_reg;
        dirty_valid = 1'b1;
        dirty_ways  = dirty_ways_reg;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign mem_wr_data_state     = INVALID;
  assign mem_wr_data_dirty_bit = 1'b0;
  assign mem_wr_data_evict_way = '0;

endmodule

// File: tb/tb_llc_rst_flush_sweep.sv
// Directed bench for llc_rst_flush_sweep: reset sweep, clean/dirty flushes, mid-sweep reset, last-set report.
module tb_llc_rst_flush_sweep;

  localparam int SB  = 9;
  localparam int NW  = 16;
  localparam int STB = 3;
  localparam int WB  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_rst = 1'b0;
  logic              start_flush = 1'b0;
  logic              dirty_ready = 1'b0;
  logic              busy, done, mem_rd_en;
  logic [SB-1:0]     mem_set;
  logic [NW-1:0]     mem_wr_rst_flush;
  logic [STB-1:0]    mem_wr_data_state;
  logic              mem_wr_data_dirty_bit;
  logic              mem_wr_en_evict_way;
  logic [WB-1:0]     mem_wr_data_evict_way;
  logic [NW*STB-1:0] rd_data_state;
  logic [NW-1:0]     rd_data_dirty_bit;
  logic              dirty_valid;
  logic [NW-1:0]     dirty_ways;

  int total = 0;
  int bad   = 0;
  int scen  = 0;
  logic [SB-1:0] rd_set_q;

  llc_rst_flush_sweep dut (
    .clk                   (clk),
    .rst                   (rst),
    .start_rst             (start_rst),
    .start_flush           (start_flush),
    .busy                  (busy),
    .done                  (done),
    .mem_rd_en             (mem_rd_en),
    .mem_set               (mem_set),
    .mem_wr_rst_flush      (mem_wr_rst_flush),
    .mem_wr_data_state     (mem_wr_data_state),
    .mem_wr_data_dirty_bit (mem_wr_data_dirty_bit),
    .mem_wr_en_evict_way   (mem_wr_en_evict_way),
    .mem_wr_data_evict_way (mem_wr_data_evict_way),
    .rd_data_state         (rd_data_state),
    .rd_data_dirty_bit     (rd_data_dirty_bit),
    .dirty_valid           (dirty_valid),
    .dirty_ways            (dirty_ways),
    .dirty_ready           (dirty_ready)
  );

  always #5 clk = ~clk;

  // Local-memory stand-in: registered read address, contents chosen per scenario.
  always @(posedge clk or posedge rst) begin
    if (rst)            rd_set_q <= '0;
    else if (mem_rd_en) rd_set_q <= mem_set;
  end

  always_comb begin
    rd_data_state     = '0;
    rd_data_dirty_bit = '0;
    if (scen == 1 && rd_set_q == 9'd5) begin
      rd_data_state[2*STB +: STB] = 3'd1;
      rd_data_state[7*STB +: STB] = 3'd3;
      rd_data_dirty_bit[7]        = 1'b1;
      rd_data_dirty_bit[9]        = 1'b1;  // stale dirty bit on an invalid way
    end
    if (scen == 2 && rd_set_q == 9'd511) begin
      rd_data_state[3*STB +: STB] = 3'd2;
      rd_data_dirty_bit[3]        = 1'b1;
      rd_data_state[4*STB +: STB] = 3'd4;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_done"},   32'(done), 32'd0);
    check({tag, "_rd_en"},  32'(mem_rd_en), 32'd0);
    check({tag, "_set"},    32'(mem_set), 32'd0);
    check({tag, "_wr"},     32'(mem_wr_rst_flush), 32'd0);
    check({tag, "_evict"},  32'(mem_wr_en_evict_way), 32'd0);
    check({tag, "_dvalid"}, 32'(dirty_valid), 32'd0);
    check({tag, "_dways"},  32'(dirty_ways), 32'd0);
  endtask

  initial begin
    int c;

    // Reset values
    #2;
    check_quiet("async_rst");
    tick;
    tick;
    rst = 1'b0;
    tick;
    check_quiet("idle");
    check("const_state", 32'(mem_wr_data_state), 32'd0);
    check("const_dirty", 32'(mem_wr_data_dirty_bit), 32'd0);
    check("const_evict", 32'(mem_wr_data_evict_way), 32'd0);
    $display("scenario reset_values total=%0d bad=%0d", total, bad);

    // Reset sweep with simultaneous flush request; extra flush pulse mid-sweep
    start_rst = 1'b1;
    start_flush = 1'b1;
    tick;
    start_rst = 1'b0;
    start_flush = 1'b0;
    for (c = 1; c <= 512; c++) begin
      check("rs_wr",    32'(mem_wr_rst_flush), 32'hFFFF);
      check("rs_evict", 32'(mem_wr_en_evict_way), 32'd1);
      check("rs_set",   32'(mem_set), 32'(c - 1));
      check("rs_rd_en", 32'(mem_rd_en), 32'd0);
      check("rs_busy",  32'(busy), 32'd1);
      check("rs_done",  32'(done), 32'd0);
      start_flush = (c == 100);
      tick;
    end
    start_flush = 1'b0;
    check("rs_done_513", 32'(done), 32'd1);
    check("rs_busy_513", 32'(busy), 32'd1);
    check("rs_wr_513",   32'(mem_wr_rst_flush), 32'd0);
    tick;
    check("rs_done_514", 32'(done), 32'd0);
    check("rs_busy_514", 32'(busy), 32'd0);
    tick;
    check("rs_no_queued_flush", 32'(busy), 32'd0);
    $display("scenario reset_sweep total=%0d bad=%0d", total, bad);

    // Flush with every line invalid
    scen = 0;
    start_flush = 1'b1;
    tick;
    start_flush = 1'b0;
    for (c = 1; c <= 1024; c++) begin
      check("fl0_rd_en", 32'(mem_rd_en), 32'(c % 2));
      check("fl0_set",   32'(mem_set), 32'((c - 1) / 2));
      check("fl0_wr",    32'(mem_wr_rst_flush), 32'd0);
      check("fl0_dv",    32'(dirty_valid), 32'd0);
      check("fl0_done",  32'(done), 32'd0);
      tick;
    end
    check("fl0_done_1025", 32'(done), 32'd1);
    tick;
    check("fl0_busy_1026", 32'(busy), 32'd0);
    $display("scenario flush_clean total=%0d bad=%0d", total, bad);

    // Flush with one clean and one dirty way in set 5, report held off 3 cycles
    scen = 1;
    start_flush = 1'b1;
    tick;
    start_flush = 1'b0;
    for (c = 1; c < 11; c++) tick;
    check("fl1_rd_set5_en", 32'(mem_rd_en), 32'd1);
    check("fl1_rd_set5",    32'(mem_set), 32'd5);
    tick;
    check("fl1_eval_wr",  32'(mem_wr_rst_flush), 32'h0004);
    check("fl1_eval_set", 32'(mem_set), 32'd5);
    check("fl1_eval_dv",  32'(dirty_valid), 32'd0);
    tick;
    for (c = 13; c <= 15; c++) begin
      check("fl1_hold_dv",    32'(dirty_valid), 32'd1);
      check("fl1_hold_dways", 32'(dirty_ways), 32'h0080);
      check("fl1_hold_set",   32'(mem_set), 32'd5);
      check("fl1_hold_wr",    32'(mem_wr_rst_flush), 32'd0);
      check("fl1_hold_rd",    32'(mem_rd_en), 32'd0);
      tick;
    end
    dirty_ready = 1'b1;
    check("fl1_hs_dv",    32'(dirty_valid), 32'd1);
    check("fl1_hs_dways", 32'(dirty_ways), 32'h0080);
    tick;
    dirty_ready = 1'b0;
    check("fl1_resume_rd",  32'(mem_rd_en), 32'd1);
    check("fl1_resume_set", 32'(mem_set), 32'd6);
    check("fl1_resume_dv",  32'(dirty_valid), 32'd0);
    c = 17;
    while (done !== 1'b1 && c < 1100) begin
      check("fl1_tail_dv", 32'(dirty_valid), 32'd0);
      check("fl1_tail_wr", 32'(mem_wr_rst_flush), 32'd0);
      tick;
      c++;
    end
    check("fl1_done_cycle", 32'(c), 32'd1029);
    tick;
    check("fl1_busy_end", 32'(busy), 32'd0);
    $display("scenario flush_dirty_set5 total=%0d bad=%0d", total, bad);

    // Asynchronous reset in the middle of a flush, then a fresh reset sweep
    scen = 0;
    start_flush = 1'b1;
    tick;
    start_flush = 1'b0;
    for (c = 1; c < 201; c++) tick;
    check("ar_rd_en_100", 32'(mem_rd_en), 32'd1);
    check("ar_set_100",   32'(mem_set), 32'd100);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("ar_immediate");
    tick;
    rst = 1'b0;
    tick;
    check_quiet("ar_after");
    start_rst = 1'b1;
    tick;
    start_rst = 1'b0;
    check("ar_restart_set",   32'(mem_set), 32'd0);
    check("ar_restart_evict", 32'(mem_wr_en_evict_way), 32'd1);
    c = 1;
    while (done !== 1'b1 && c < 600) begin
      tick;
      c++;
    end
    check("ar_restart_done_cycle", 32'(c), 32'd513);
    tick;
    $display("scenario mid_sweep_rst total=%0d bad=%0d", total, bad);

    // Dirty line in the last set ends the sweep without touching set 0
    scen = 2;
    start_flush = 1'b1;
    tick;
    start_flush = 1'b0;
    for (c = 1; c < 1024; c++) tick;
    check("ls_eval_set", 32'(mem_set), 32'd511);
    check("ls_eval_wr",  32'(mem_wr_rst_flush), 32'h0010);
    check("ls_eval_dv",  32'(dirty_valid), 32'd0);
    tick;
    check("ls_rep_dv",    32'(dirty_valid), 32'd1);
    check("ls_rep_dways", 32'(dirty_ways), 32'h0008);
    check("ls_rep_set",   32'(mem_set), 32'd511);
    dirty_ready = 1'b1;
    tick;
    dirty_ready = 1'b0;
    check("ls_done",  32'(done), 32'd1);
    check("ls_rd_en", 32'(mem_rd_en), 32'd0);
    check("ls_wr",    32'(mem_wr_rst_flush), 32'd0);
    check("ls_dv",    32'(dirty_valid), 32'd0);
    check("ls_busy",  32'(busy), 32'd1);
    tick;
    check_quiet("ls_idle");
    $display("scenario last_set_dirty total=%0d bad=%0d", total, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
